controlador_dispositivo: RTL and testbench

//  Memory-mapped device controller between a CPU-side bus and one output device.

---
 rtl/controlador_dispositivo.sv | 57 +++++
 tb/tb_controlador_dispositivo.sv | 136 +++++++++++++
 2 files changed

// File: rtl/controlador_dispositivo.sv
// Memory-mapped controller for one output device: decodes CPU transactions,
// holds the device data register and a write-count status register, and forwards every transaction registered.
module controlador_dispositivo #(
  parameter int          DATA_W      = 32,
  parameter logic [31:0] DEVICE_ADDR = 32'hFFFF_FFFF,
  parameter logic [31:0] STATUS_ADDR = 32'hFFFF_FFFE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       address_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rw,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] data_device,
  output logic              rw_out,
  output logic [31:0]       address_out
);

  logic              dev_hit;
  logic              sts_hit;
  logic [DATA_W-1:0] device_reg;
  logic [DATA_W-1:0] wr_cnt;

  assign dev_hit     = (address_in == DEVICE_ADDR);
  assign sts_hit     = (address_in == STATUS_ADDR);
  assign data_device = device_reg;

  // Single registered stage: decode, update state and forward the transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out    <= '0;
      device_reg  <= '0;
      wr_cnt      <= '0;
      rw_out      <= 1'b0;
      address_out <= '0;
    end else begin
      address_out <= address_in;
      rw_out      <= rw;
      data_out    <= '0;
      if (rw) begin
        if (dev_hit) begin
          device_reg <= data_in;
          wr_cnt     <= wr_cnt + 1'b1;
        end else if (sts_hit) begin
          wr_cnt <= '0;
        end
      end else begin
        // Reads return the value held before this edge.
        if (dev_hit)
          data_out <= device_reg;
        else if (sts_hit)
          data_out <= wr_cnt;
      end
    end
  end

endmodule

// File: tb/tb_controlador_dispositivo.sv
// Directed-vector bench for controlador_dispositivo: a driver pushes hand-computed
// expectations into a queue, and an independent monitor pops and compares each cycle.
module tb_controlador_dispositivo;

  logic        clock;
  logic        reset;
  logic [31:0] address_in;
  logic [31:0] data_in;
  logic        rw;
  logic [31:0] data_out;
  logic [31:0] data_device;
  logic        rw_out;
  logic [31:0] address_out;

  controlador_dispositivo dut (
    .clock       (clock),
    .reset       (reset),
    .address_in  (address_in),
    .data_in     (data_in),
    .rw          (rw),
    .data_out    (data_out),
    .data_device (data_device),
    .rw_out      (rw_out),
    .address_out (address_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] e_dout;
    logic [31:0] e_dev;
    logic        e_rw;
    logic [31:0] e_addr;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] e_dout;
    logic [31:0] e_dev;
    logic        e_rw;
    logic [31:0] e_addr;
    string       name;
  } exp_t;

  localparam logic [31:0] DEV = 32'hFFFF_FFFF;
  localparam logic [31:0] STS = 32'hFFFF_FFFE;
  localparam logic [31:0] OTH = 32'h0000_0010;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  bit   done   = 0;

  task automatic add(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] edo, input logic [31:0] edv, input logic erw,
                     input logic [31:0] ea, input string n);
    vec_t v;
    v.rst = r; v.rw = w; v.addr = a; v.data = d;
    v.e_dout = edo; v.e_dev = edv; v.e_rw = erw; v.e_addr = ea; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", n, act, req);
  endtask

  // Driver
  initial begin
    reset = 1'b1; rw = 1'b0; address_in = '0; data_in = '0;
    //   rst rw addr  data           dout           dev            rw_o addr_o name
    add(1, 1, DEV, 32'h2,          32'h0,         32'h0,         0,   32'h0, "reset0");
    add(1, 1, DEV, 32'h2,          32'h0,         32'h0,         0,   32'h0, "reset1");
    for (int i = 0; i < 5; i++)
      add(0, 1, DEV, 32'h2,        32'h0,         32'h2,         1,   DEV,   "devwr");
    add(0, 0, STS, 32'h0,          32'h5,         32'h2,         0,   STS,   "stsrd5");
    add(0, 1, STS, 32'h77,         32'h0,         32'h2,         1,   STS,   "stswr");
    add(0, 0, STS, 32'h0,          32'h0,         32'h2,         0,   STS,   "stsrd0");
    add(0, 1, DEV, 32'hA5A5_0001,  32'h0,         32'hA5A5_0001, 1,   DEV,   "devwrA5");
    add(0, 0, DEV, 32'h0,          32'hA5A5_0001, 32'hA5A5_0001, 0,   DEV,   "devrd");
    add(0, 1, OTH, 32'h1234,       32'h0,         32'hA5A5_0001, 1,   OTH,   "othwr");
    add(0, 0, OTH, 32'hFFFF,       32'h0,         32'hA5A5_0001, 0,   OTH,   "othrd");
    add(0, 0, STS, 32'h0,          32'h1,         32'hA5A5_0001, 0,   STS,   "stsrd1");
    add(0, 1, DEV, 32'h3,          32'h0,         32'h3,         1,   DEV,   "strm");
    add(0, 1, DEV, 32'h3,          32'h0,         32'h3,         1,   DEV,   "strm");
    add(1, 1, DEV, 32'h3,          32'h0,         32'h0,         0,   32'h0, "midrst");
    add(0, 1, DEV, 32'h7,          32'h0,         32'h7,         1,   DEV,   "postrst");
    add(0, 0, STS, 32'h0,          32'h1,         32'h7,         0,   STS,   "cntrst");
    add(0, 0, DEV, 32'h0,          32'h7,         32'h7,         0,   DEV,   "devrd7");

    foreach (vecs[i]) begin
      exp_t e;
      @(negedge clock);
      reset = vecs[i].rst; rw = vecs[i].rw;
      address_in = vecs[i].addr; data_in = vecs[i].data;
      e.e_dout = vecs[i].e_dout; e.e_dev = vecs[i].e_dev;
      e.e_rw = vecs[i].e_rw; e.e_addr = vecs[i].e_addr; e.name = vecs[i].name;
      sb.push_back(e);
    end
    @(negedge clock);
    done = 1;
  end

  // Monitor
  initial begin
    int cyc = 0;
    exp_t e;
    while (!(done && sb.size() == 0)) begin
      @(posedge clock);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".data_out"},    data_out,            e.e_dout);
        check({e.name, ".data_device"}, data_device,         e.e_dev);
        check({e.name, ".rw_out"},      {31'b0, rw_out},     {31'b0, e.e_rw});
        check({e.name, ".address_out"}, address_out,         e.e_addr);
      end
      if (cyc > 1000) begin
        checks++;
        $display("FAIL timeout: cycles %0d, expected at most 1000", cyc);
        break;
      end
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
